// File: rtl/io_bin2bcd.sv
// rtl/io_bin2bcd.sv - iterative double-dabble binary-to-BCD converter, one bit per clock
// Optional blank_mask output enabled by IO_BIN2BCD_BLANK_EN.
`timescale 1ns/1ps
module io_bin2bcd #(
    parameter int BIN_W = 20,
    parameter int NDIG  = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic                ovf
`ifdef IO_BIN2BCD_BLANK_EN
    ,
    output logic [NDIG-1:0]     blank_mask
`endif
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] max_dec(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC = max_dec(NDIG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   sh;
    logic [BCD_W-1:0]   acc;
    logic               ovf_pend;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   acc_nxt;
    logic [BIN_W-1:0]   sh_nxt;

    // Add-3 correction per digit, then shift the combined register left by one.
    always_comb begin
        adj = acc;
        for (int i = 0; i < NDIG; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        acc_nxt = {adj[BCD_W-2:0], sh[BIN_W-1]};
        sh_nxt  = {sh[BIN_W-2:0], 1'b0};
    end

`ifdef IO_BIN2BCD_BLANK_EN
    logic [NDIG-1:0] mask_nxt;
    logic            zero_above;

    // Leading-zero digits are blanked; digit 0 always stays lit.
    always_comb begin
        mask_nxt   = '0;
        zero_above = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_above  = zero_above & (acc_nxt[4*i +: 4] == 4'd0);
            mask_nxt[i] = zero_above;
        end
        mask_nxt[0] = 1'b0;
    end
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sh       <= '0;
            acc      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            ovf      <= 1'b0;
`ifdef IO_BIN2BCD_BLANK_EN
            blank_mask <= {{(NDIG-1){1'b1}}, 1'b0};
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh       <= bin_in;
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_pend <= (64'(bin_in) > MAX_DEC);
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc <= acc_nxt;
                    sh  <= sh_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        if (ovf_pend) begin
                            bcd_out <= {NDIG{4'h9}};
                            ovf     <= 1'b1;
`ifdef IO_BIN2BCD_BLANK_EN
                            blank_mask <= '0;
`endif
                        end else begin
                            bcd_out <= acc_nxt;
                            ovf     <= 1'b0;
`ifdef IO_BIN2BCD_BLANK_EN
                            blank_mask <= mask_nxt;
`endif
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bin2bcd.sv
// tb/tb_io_bin2bcd.sv - directed self-checking bench for io_bin2bcd
`timescale 1ns/1ps
module tb_io_bin2bcd;

    logic        clock;
    logic        reset;
    logic        start;
    logic [19:0] bin_in;
    logic        busy;
    logic        done;
    logic [23:0] bcd_out;
    logic        ovf;
`ifdef IO_BIN2BCD_BLANK_EN
    logic [5:0]  blank_mask;
`endif

    int checks   = 0;
    int failures = 0;

    io_bin2bcd #(.BIN_W(20), .NDIG(6)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
`ifdef IO_BIN2BCD_BLANK_EN
        ,
        .blank_mask (blank_mask)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge where done is seen.
    task automatic do_conv(input logic [19:0] v, output int lat, output int busy_cnt);
        start    = 1'b1;
        bin_in   = v;
        lat      = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat, bcnt, dcount, acc_n, dn;
    int done_k [3];
    logic [23:0] done_v [3];
    logic [19:0] b2b_vals [3];
    logic prev_busy;
`ifdef IO_BIN2BCD_BLANK_EN
    logic [5:0] done_m [3];
`endif

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
`ifdef IO_BIN2BCD_BLANK_EN
        check("rst_mask", 32'(blank_mask), 32'h3e);
`endif

        do_conv(20'h03039, lat, bcnt);
        check("basic_lat", 32'(lat), 32'd21);
        check("basic_busy", 32'(bcnt), 32'd21);
        check("basic_bcd", 32'(bcd_out), 32'h012345);
        check("basic_ovf", 32'(ovf), 32'h0);
        @(negedge clock);
        check("basic_done_clr", 32'(done), 32'h0);
        check("basic_idle", 32'(busy), 32'h0);
        check("basic_hold", 32'(bcd_out), 32'h012345);

        // Reset asserted mid-cycle during the done pulse must clear at once.
        do_conv(20'd42, lat, bcnt);
        check("b42_bcd", 32'(bcd_out), 32'h000042);
`ifdef IO_BIN2BCD_BLANK_EN
        check("b42_mask", 32'(blank_mask), 32'h3c);
`endif
        #2 reset = 1'b1;
        #1;
        check("arst_done", 32'(done), 32'h0);
        check("arst_bcd", 32'(bcd_out), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_ovf", 32'(ovf), 32'h0);
`ifdef IO_BIN2BCD_BLANK_EN
        check("arst_mask", 32'(blank_mask), 32'h3e);
`endif
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        do_conv(20'hF423F, lat, bcnt);
        check("max_bcd", 32'(bcd_out), 32'h999999);
        check("max_ovf", 32'(ovf), 32'h0);
        @(negedge clock);
        do_conv(20'hF4240, lat, bcnt);
        check("ovf1_bcd", 32'(bcd_out), 32'h999999);
        check("ovf1_ovf", 32'(ovf), 32'h1);
`ifdef IO_BIN2BCD_BLANK_EN
        check("ovf1_mask", 32'(blank_mask), 32'h0);
`endif
        @(negedge clock);
        do_conv(20'hFFFFF, lat, bcnt);
        check("ovf2_bcd", 32'(bcd_out), 32'h999999);
        check("ovf2_ovf", 32'(ovf), 32'h1);
        @(negedge clock);
        do_conv(20'h0, lat, bcnt);
        check("zero_lat", 32'(lat), 32'd21);
        check("zero_bcd", 32'(bcd_out), 32'h0);
        check("zero_ovf", 32'(ovf), 32'h0);
        @(negedge clock);

        // A second start during SHIFT must be ignored entirely.
        start  = 1'b1;
        bin_in = 20'd7;
        dcount = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
            if (k == 5) begin
                start  = 1'b1;
                bin_in = 20'd500;
            end
            if (k == 6) start = 1'b0;
            if (done) dcount++;
        end
        check("busy_start_dones", 32'(dcount), 32'd1);
        check("busy_start_bcd", 32'(bcd_out), 32'h000007);

        start  = 1'b1;
        bin_in = 20'd654321;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
        end
        check("midrst_busy_pre", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_bcd", 32'(bcd_out), 32'h0);
        @(negedge clock);
        reset  = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (done) dcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        check("midrst_bcd_hold", 32'(bcd_out), 32'h0);
        do_conv(20'd1, lat, bcnt);
        check("after_rst_bcd", 32'(bcd_out), 32'h000001);
        @(negedge clock);

        // Back-to-back with start held high; bin_in advances on each accepted edge.
        b2b_vals[0] = 20'd0;
        b2b_vals[1] = 20'd9;
        b2b_vals[2] = 20'd10;
        start     = 1'b1;
        bin_in    = b2b_vals[0];
        acc_n     = 0;
        dn        = 0;
        prev_busy = 1'b0;
        for (int k = 1; k <= 200 && dn < 3; k++) begin
            @(negedge clock);
            if (busy && !prev_busy) begin
                acc_n++;
                if (acc_n < 3) bin_in = b2b_vals[acc_n];
            end
            prev_busy = busy;
            if (done) begin
                done_k[dn] = k;
                done_v[dn] = bcd_out;
`ifdef IO_BIN2BCD_BLANK_EN
                done_m[dn] = blank_mask;
`endif
                dn++;
                if (dn == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_dones", 32'(dn), 32'd3);
        if (dn == 3) begin
            check("b2b_gap1", 32'(done_k[1] - done_k[0]), 32'd22);
            check("b2b_gap2", 32'(done_k[2] - done_k[1]), 32'd22);
            check("b2b_v0", 32'(done_v[0]), 32'h000000);
            check("b2b_v1", 32'(done_v[1]), 32'h000009);
            check("b2b_v2", 32'(done_v[2]), 32'h000010);
`ifdef IO_BIN2BCD_BLANK_EN
            check("b2b_m0", 32'(done_m[0]), 32'h3e);
            check("b2b_m1", 32'(done_m[1]), 32'h3e);
            check("b2b_m2", 32'(done_m[2]), 32'h3c);
`endif
        end
        repeat (3) @(negedge clock);
        check("b2b_stop", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
